alu_vec_sequencer: RTL

- Upstream stimulus/checker stage for the on-board ALU test harness.
- Replaces hardcoded operands with a loadable table of NUM_VECS test vectors (operand_a, operand_b, alu_ctrl, expected o, expected nzc).
- On start, drives each vector into the ALU, waits for the ALU to settle, compares the ALU output against the expected values, and shows per-vector and final status on the 4 LEDs.

---
 rtl/alu_vec_sequencer.sv | 206 ++++++++++++++++++++
 1 files changed

// File: rtl/alu_vec_sequencer.sv
// Loadable test-vector sequencer for the on-board ALU harness: applies each table entry,
// samples the combinational ALU after a settle time, and reports per-vector/final status on LEDs.
module alu_vec_sequencer #(
    parameter int NUM_VECS      = 8,
    parameter int IDX_W         = 3,
    parameter int SETTLE_CYCLES = 2,
    parameter int DWELL_CYCLES  = 50000000
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             vec_we,
    input  logic [IDX_W-1:0] vec_addr,
    input  logic [108:0]     vec_wdata,
    output logic [31:0]      operand_a,
    output logic [31:0]      operand_b,
    output logic [5:0]       alu_ctrl,
    input  logic [31:0]      alu_o,
    input  logic [2:0]       alu_nzc,
    output logic [3:0]       led,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [IDX_W-1:0] vec_idx
);

    localparam int SET_W = (SETTLE_CYCLES < 2) ? 1 : $clog2(SETTLE_CYCLES + 1);
    localparam int DWL_W = (DWELL_CYCLES < 2) ? 1 : $clog2(DWELL_CYCLES + 1);

    // The concatenated fields occupy the low 105 bits of the write word; the top 4 bits carry nothing.
    typedef struct packed {
        logic [31:0] a;
        logic [31:0] b;
        logic [5:0]  ctrl;
        logic [31:0] exp_o;
        logic [2:0]  exp_nzc;
    } vec_t;

    typedef enum logic [2:0] {
        S_IDLE,
        S_APPLY,
        S_CHECK,
        S_DWELL,
        S_DONE
    } state_e;

    vec_t table_mem [NUM_VECS];

    state_e           state_q, state_d;
    logic [31:0]      operand_a_q, operand_a_d;
    logic [31:0]      operand_b_q, operand_b_d;
    logic [5:0]       alu_ctrl_q, alu_ctrl_d;
    logic [31:0]      exp_o_q, exp_o_d;
    logic [2:0]       exp_nzc_q, exp_nzc_d;
    logic [3:0]       led_q, led_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             pass_q, pass_d;
    logic [IDX_W-1:0] vec_idx_q, vec_idx_d;
    logic [2:0]       fail_cnt_q, fail_cnt_d;
    logic [SET_W-1:0] settle_cnt_q, settle_cnt_d;
    logic [DWL_W-1:0] dwell_cnt_q, dwell_cnt_d;

    vec_t             wr_ent;
    vec_t             load_ent;
    logic             load_en;
    logic             table_wr_en;
    logic [IDX_W-1:0] next_idx;
    logic             mismatch;
    logic [3:0]       unused_wdata_bits;

    assign wr_ent            = vec_t'(vec_wdata[104:0]);
    assign unused_wdata_bits = vec_wdata[108:105];
    assign table_wr_en       = vec_we && ((state_q == S_IDLE) || (state_q == S_DONE));
    assign next_idx          = vec_idx_q + IDX_W'(1);
    assign mismatch          = (alu_o != exp_o_q) || (alu_nzc != exp_nzc_q);

    // Vector table: not reset, written only while the sequencer is idle or done.
    always_ff @(posedge clk) begin
        if (table_wr_en) begin
            table_mem[vec_addr] <= wr_ent;
        end
    end

    always_comb begin
        state_d      = state_q;
        operand_a_d  = operand_a_q;
        operand_b_d  = operand_b_q;
        alu_ctrl_d   = alu_ctrl_q;
        exp_o_d      = exp_o_q;
        exp_nzc_d    = exp_nzc_q;
        led_d        = led_q;
        vec_idx_d    = vec_idx_q;
        fail_cnt_d   = fail_cnt_q;
        settle_cnt_d = settle_cnt_q;
        dwell_cnt_d  = dwell_cnt_q;
        load_en      = 1'b0;
        load_ent     = table_mem[0];

        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    vec_idx_d    = '0;
                    fail_cnt_d   = '0;
                    settle_cnt_d = '0;
                    load_en      = 1'b1;
                    // A write to entry 0 on the start edge must be visible to the run it launches.
                    load_ent     = (vec_we && (vec_addr == '0)) ? wr_ent : table_mem[0];
                    state_d      = S_APPLY;
                end
            end
            S_APPLY: begin
                settle_cnt_d = settle_cnt_q + SET_W'(1);
                if (settle_cnt_q == SET_W'(SETTLE_CYCLES - 1)) begin
                    state_d = S_CHECK;
                end
            end
            S_CHECK: begin
                if (mismatch && (fail_cnt_q != 3'd7)) begin
                    fail_cnt_d = fail_cnt_q + 3'd1;
                end
                led_d       = alu_o[3:0];
                dwell_cnt_d = '0;
                state_d     = S_DWELL;
            end
            S_DWELL: begin
                if (dwell_cnt_q == DWL_W'(DWELL_CYCLES - 1)) begin
                    if (vec_idx_q == IDX_W'(NUM_VECS - 1)) begin
                        state_d = S_DONE;
                    end else begin
                        vec_idx_d    = next_idx;
                        settle_cnt_d = '0;
                        load_en      = 1'b1;
                        load_ent     = table_mem[next_idx];
                        state_d      = S_APPLY;
                    end
                end else begin
                    dwell_cnt_d = dwell_cnt_q + DWL_W'(1);
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (load_en) begin
            operand_a_d = load_ent.a;
            operand_b_d = load_ent.b;
            alu_ctrl_d  = load_ent.ctrl;
            exp_o_d     = load_ent.exp_o;
            exp_nzc_d   = load_ent.exp_nzc;
        end

        // Status flags are derived from the next state so they are registered like every output.
        busy_d = (state_d == S_APPLY) || (state_d == S_CHECK) || (state_d == S_DWELL);
        done_d = (state_d == S_DONE);
        pass_d = (state_d == S_DONE) && (fail_cnt_d == 3'd0);
        if (state_d == S_DONE) begin
            led_d = {pass_d, fail_cnt_d};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            operand_a_q  <= '0;
            operand_b_q  <= '0;
            alu_ctrl_q   <= '0;
            exp_o_q      <= '0;
            exp_nzc_q    <= '0;
            led_q        <= '0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            pass_q       <= 1'b0;
            vec_idx_q    <= '0;
            fail_cnt_q   <= '0;
            settle_cnt_q <= '0;
            dwell_cnt_q  <= '0;
        end else begin
            state_q      <= state_d;
            operand_a_q  <= operand_a_d;
            operand_b_q  <= operand_b_d;
            alu_ctrl_q   <= alu_ctrl_d;
            exp_o_q      <= exp_o_d;
            exp_nzc_q    <= exp_nzc_d;
            led_q        <= led_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            pass_q       <= pass_d;
            vec_idx_q    <= vec_idx_d;
            fail_cnt_q   <= fail_cnt_d;
            settle_cnt_q <= settle_cnt_d;
            dwell_cnt_q  <= dwell_cnt_d;
        end
    end

    assign operand_a = operand_a_q;
    assign operand_b = operand_b_q;
    assign alu_ctrl  = alu_ctrl_q;
    assign led       = led_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign pass      = pass_q;
    assign vec_idx   = vec_idx_q;

endmodule
